// File: rtl/dp_memory_pkg.sv
// dp_memory_pkg: shared FSM state type for dp_memory and its clear controller
package dp_memory_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/mem_clear_ctrl.sv
// mem_clear_ctrl: clear-sweep FSM, walks every address once and drives a zero-write enable
module mem_clear_ctrl #(
    parameter int SIZE     = 256,
    parameter int ADR_SIZE = $clog2(SIZE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    output logic                busy_o,
    output logic [ADR_SIZE-1:0] clr_adr_o,
    output logic                clr_we_o
);
    import dp_memory_pkg::*;

    localparam logic [ADR_SIZE-1:0] LAST = ADR_SIZE'(SIZE - 1);

    state_t              r_state, w_state_nx;
    logic [ADR_SIZE-1:0] r_cnt, w_cnt_nx;

    // state and sweep counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // start a sweep from IDLE, step one address per cycle, return after the last one
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == IDLE && clear_i) begin
            w_state_nx = CLEAR;
            w_cnt_nx   = '0;
        end else if (r_state == CLEAR) begin
            w_state_nx = (r_cnt == LAST) ? IDLE : CLEAR;
            w_cnt_nx   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign busy_o    = (r_state == CLEAR);
    assign clr_adr_o = r_cnt;
    // a reset edge aborts the sweep without zeroing the word in flight
    assign clr_we_o  = busy_o && !rst_i;
endmodule

// File: rtl/dp_memory.sv
// dp_memory: SIZE x WORD dual-port RAM, 1-cycle registered read, background clear sweep.
// Define DP_MEMORY_BYPASS_EN for write-first same-address reads (read-first otherwise).
module dp_memory #(
    parameter  int WORD     = 8,
    parameter  int SIZE     = 256,
    localparam int ADR_SIZE = $clog2(SIZE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic [ADR_SIZE-1:0] wr_adr_i,
    input  logic [WORD-1:0]     wr_data_i,
    input  logic                rd_i,
    input  logic [ADR_SIZE-1:0] rd_adr_i,
    output logic [WORD-1:0]     rd_data_o,
    output logic                rd_valid_o,
    input  logic                clear_i,
    output logic                busy_o
);
    import dp_memory_pkg::*;

    localparam logic [ADR_SIZE:0] SIZE_L = (ADR_SIZE + 1)'(SIZE);

    logic [WORD-1:0]     r_mem [SIZE];
    logic [WORD-1:0]     r_rd_data;
    logic                r_rd_valid;
    logic                w_busy, w_clr_we, w_wr_en, w_rd_in, w_hit;
    logic [ADR_SIZE-1:0] w_clr_adr;
    logic [WORD-1:0]     w_rd_word;

    mem_clear_ctrl #(.SIZE(SIZE)) u_clr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .busy_o    (w_busy),
        .clr_adr_o (w_clr_adr),
        .clr_we_o  (w_clr_we)
    );

    // user write only in IDLE, in range, and not losing to a clear request
    assign w_wr_en = wr_i && !rst_i && !clear_i && !w_busy && ({1'b0, wr_adr_i} < SIZE_L);
    assign w_rd_in = {1'b0, rd_adr_i} < SIZE_L;
`ifdef DP_MEMORY_BYPASS_EN
    assign w_hit = w_wr_en && (wr_adr_i == rd_adr_i);
`else
    assign w_hit = 1'b0;
`endif
    assign w_rd_word = w_hit ? wr_data_i : r_mem[rd_adr_i];

    // storage: the clear sweep owns the write port while busy
    always_ff @(posedge clk_i) begin
        if (w_clr_we)
            r_mem[w_clr_adr] <= '0;
        else if (w_wr_en)
            r_mem[wr_adr_i] <= wr_data_i;
    end

    // registered read port; data holds between accepted reads, out-of-range reads give zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (rd_i && !w_busy) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_rd_in ? w_rd_word : '0;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign busy_o     = w_busy;
endmodule

// File: tb/tb_dp_memory.sv
// tb_dp_memory: scoreboard bench for dp_memory (256 words) plus a 200-word instance for range checks
module tb_dp_memory;
    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0, wr_i = 1'b0, rd_i = 1'b0, clear_i = 1'b0;
    logic [7:0] wr_adr_i = '0, wr_data_i = '0, rd_adr_i = '0;
    logic [7:0] rd_data_o;
    logic       rd_valid_o, busy_o;

    logic       rst2 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
    logic [7:0] wa2 = '0, wd2 = '0, ra2 = '0, rdata2;
    logic       rvalid2, busy2;

    exp_t       q [$];
    logic [7:0] m_mem [256];
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_data = '0;
    int         n_chk = 0, n_fail = 0;
    int         run_len = 0, last_len = 0;

    always #5 clk = ~clk;

    dp_memory #(.WORD(8), .SIZE(256)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .wr_adr_i(wr_adr_i), .wr_data_i(wr_data_i),
        .rd_i(rd_i), .rd_adr_i(rd_adr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .clear_i(clear_i), .busy_o(busy_o)
    );

    dp_memory #(.WORD(8), .SIZE(200)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .wr_i(wr2), .wr_adr_i(wa2), .wr_data_i(wd2),
        .rd_i(rd2), .rd_adr_i(ra2), .rd_data_o(rdata2), .rd_valid_o(rvalid2),
        .clear_i(1'b0), .busy_o(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle of stimulus and push the reference model's view of the outputs after the edge
    task automatic step(input bit rst, input bit clr, input bit wr, input logic [7:0] wa,
                        input logic [7:0] wd, input bit rd, input logic [7:0] ra);
        exp_t e;
        bit   byp;
        @(negedge clk);
        rst_i = rst; clear_i = clr; wr_i = wr; wr_adr_i = wa; wr_data_i = wd; rd_i = rd; rd_adr_i = ra;
`ifdef DP_MEMORY_BYPASS_EN
        byp = wr && !clr && (wa == ra);
`else
        byp = 1'b0;
`endif
        if (rst) begin
            m_busy = 1'b0; m_cnt = 0; e.valid = 1'b0; m_data = '0;
        end else if (m_busy) begin
            m_mem[m_cnt] = '0;
            e.valid = 1'b0;
            m_cnt++;
            if (m_cnt == 256) begin
                m_busy = 1'b0; m_cnt = 0;
            end
        end else begin
            e.valid = rd;
            if (rd) m_data = byp ? wd : m_mem[ra];
            if (clr) begin
                m_busy = 1'b1; m_cnt = 0;
            end else if (wr) m_mem[wa] = wd;
        end
        e.data = m_data;
        e.busy = m_busy;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    endtask

    // compare DUT outputs against the scoreboard just after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_valid", {31'b0, rd_valid_o}, {31'b0, e.valid});
            chk("rd_data", {24'b0, rd_data_o}, {24'b0, e.data});
            chk("busy", {31'b0, busy_o}, {31'b0, e.busy});
        end
        if (busy_o) run_len++;
        else if (run_len != 0) begin
            last_len = run_len;
            run_len = 0;
        end
    end

    initial begin
        step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        step(1, 0, 1, 8'h10, 8'h11, 1, 8'h10);
        step(0, 0, 1, 8'h10, 8'hA5, 0, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00, 1, 8'h10);
        idle(2);
        step(0, 0, 1, 8'h20, 8'h3C, 0, 8'h00);
        step(0, 0, 1, 8'h20, 8'h77, 1, 8'h20);
        step(0, 0, 0, 8'h00, 8'h00, 1, 8'h20);
        idle(1);
        for (int a = 0; a < 256; a++) step(0, 0, 1, 8'(a), 8'(a ^ 8'hC3), 0, 8'h00);
        for (int i = 0; i < 60; i++)
            step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
        for (int a = 0; a < 256; a++) step(0, 0, 1, 8'(a), 8'(a), 0, 8'h00);
        step(0, 1, 1, 8'h05, 8'h99, 1, 8'h30);
        for (int i = 0; i < 256; i++)
            step(0, 1'($urandom_range(0, 1)), 1, 8'($urandom), 8'($urandom), 1, 8'($urandom));
        idle(2);
        chk("busy_len_full", 32'(last_len), 32'd256);
        for (int a = 0; a < 256; a++) step(0, 0, 0, 8'h00, 8'h00, 1, 8'(a));
        for (int a = 0; a < 256; a++) step(0, 0, 1, 8'(a), 8'(a ^ 8'h5A), 0, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
        idle(100);
        step(1, 0, 1, 8'h01, 8'hEE, 1, 8'h02);
        idle(1);
        chk("busy_len_abort", 32'(last_len), 32'd101);
        for (int a = 0; a < 256; a++) step(0, 0, 0, 8'h00, 8'h00, 1, 8'(a));
        idle(3);
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0; wr2 = 1'b1; wa2 = 8'd199; wd2 = 8'h42;
        @(negedge clk);
        wa2 = 8'd210; wd2 = 8'hFF;
        @(negedge clk);
        wr2 = 1'b0; rd2 = 1'b1; ra2 = 8'd210;
        @(negedge clk);
        chk("oor_valid", {31'b0, rvalid2}, 32'd1);
        chk("oor_data", {24'b0, rdata2}, 32'h00);
        ra2 = 8'd199;
        @(negedge clk);
        chk("s200_valid", {31'b0, rvalid2}, 32'd1);
        chk("s200_data", {24'b0, rdata2}, 32'h42);
        rd2 = 1'b0;
        @(negedge clk);
        chk("s200_hold_valid", {31'b0, rvalid2}, 32'd0);
        chk("s200_hold_data", {24'b0, rdata2}, 32'h42);
        chk("s200_busy", {31'b0, busy2}, 32'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
